// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
// Used by fetch_fifo and fetch_unit.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
    logic                  fault;
  } fetch_entry_t;

  // Byte PC to word index; the caller truncates the result to the memory depth.
  function automatic logic [FETCH_XLEN-1:0] word_addr(input logic [FETCH_XLEN-1:0] pc);
    return pc >> 2;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t with a synchronous flush and an occupancy count.
// DEPTH must be a power of two, so the pointers wrap without extra logic.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           push_entry,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t  entries_q [DEPTH];
  fetch_entry_t  entries_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_push   = push && (count_q != (PW+1)'(DEPTH));
    do_pop    = pop && (count_q != '0);
    if (reset || flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        entries_d[wr_ptr_q] = push_entry;
        wr_ptr_d            = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // Payload storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  assign head  = entries_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC sequencer, synchronous-read instruction memory and prefetch FIFO.
// Optional feature macro FETCH_FAULT_EN adds fetch_fault reporting for misaligned/out-of-range PCs.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN       = 32,
  parameter int unsigned      IMEM_DEPTH = 64,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0]  RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [XLEN-1:0]               imem_wdata,
  output logic                          if_valid,
  input  logic                          if_ready,
  output logic [XLEN-1:0]               if_pc,
  output logic [XLEN-1:0]               if_instr
`ifdef FETCH_FAULT_EN
  ,
  output logic                          fetch_fault
`endif
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0]       imem [IMEM_DEPTH];
  logic [XLEN-1:0]       pc_q, pc_d;
  logic                  rd_valid_q, rd_valid_d;
  fetch_entry_t          rd_entry_q, rd_entry_d;
  logic [FETCH_XLEN-1:0] pc_word;
  logic [AW-1:0]         raddr;
  logic                  addr_fault;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic [CW-1:0]         fifo_count;
  fetch_entry_t          head;

  always_comb begin
    pc_word = word_addr(FETCH_XLEN'(pc_q));
    raddr   = pc_word[AW-1:0];
`ifdef FETCH_FAULT_EN
    addr_fault = (pc_q[1:0] != 2'b00) || (pc_word >= FETCH_XLEN'(IMEM_DEPTH));
`else
    addr_fault = 1'b0;
`endif
  end

  // A read issues only when a FIFO slot is reserved for it, counting the one in flight.
  always_comb begin
    issue = !reset && !redirect_valid &&
            ((fifo_count + CW'(rd_valid_q)) < CW'(FIFO_DEPTH));
    push  = rd_valid_q && !redirect_valid && !reset;
    pop   = if_valid && if_ready && !reset;
  end

  // Redirect outranks issue and kills the in-flight read; reset outranks everything.
  always_comb begin
    pc_d       = pc_q;
    rd_valid_d = rd_valid_q;
    rd_entry_d = rd_entry_q;
    if (reset) begin
      pc_d       = RESET_PC;
      rd_valid_d = 1'b0;
      rd_entry_d = '0;
    end else if (redirect_valid) begin
      pc_d       = redirect_pc;
      rd_valid_d = 1'b0;
    end else begin
      rd_valid_d = issue;
      if (issue) begin
        pc_d             = pc_q + XLEN'(PC_STEP);
        rd_entry_d.pc    = FETCH_XLEN'(pc_q);
        rd_entry_d.instr = addr_fault ? '0 : FETCH_XLEN'(imem[raddr]);
        rd_entry_d.fault = addr_fault;
      end else begin
        rd_entry_d = rd_entry_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    pc_q       <= pc_d;
    rd_valid_q <= rd_valid_d;
    rd_entry_q <= rd_entry_d;
  end

  // Program-load port; the read above samples the old word, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (!reset && imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .pop        (pop),
    .push_entry (rd_entry_q),
    .head       (head),
    .count      (fifo_count)
  );

  always_comb begin
    if_valid = (fifo_count != '0);
    if_pc    = if_valid ? XLEN'(head.pc) : '0;
    if_instr = if_valid ? XLEN'(head.instr) : '0;
`ifdef FETCH_FAULT_EN
    fetch_fault = if_valid && head.fault;
`endif
  end

`ifndef FETCH_FAULT_EN
  logic unused_bits;
  assign unused_bits = ^{head.fault, pc_word[FETCH_XLEN-1:AW]};
`endif

endmodule
